// File: rtl/mips_defs_pkg.sv
// Shared MIPS front-end definitions: sequencer states, word size and default reset vector.
package mips_defs_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // J-type target keeps the region bits of the delay-slot address.
    function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                               input logic [25:0] index);
        return {pcPlus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/adder_32.sv
// Plain 32-bit adder; results wrap modulo 2^32 and the carry-out is discarded.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: boots, fetches sequentially, takes redirects and traps on misaligned JR.
module pc_sequencer
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        misaligned
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pendValid_q, pendValid_d;
    logic [31:0] pendTarget_q, pendTarget_d;
    logic        pendBad_q, pendBad_d;
    logic        fetchValid_q, fetchValid_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic        advance;
    logic        redirValid;
    logic [31:0] redirTarget;
    logic        redirBad;
    logic [31:0] nextTarget;
    logic        nextBad;

    adder_32 u_pcInc (
        .a   (pc_q),
        .b   (WORD_BYTES),
        .sum (pcPlus4)
    );

    // branch_offset arrives pre-shifted, so it is added as-is.
    adder_32 u_branchTarget (
        .a   (pcPlus4),
        .b   (branch_offset),
        .sum (branchTarget)
    );

    assign advance = imem_ready & ~stall;

    always_comb begin
        redirValid  = jump_reg | jump | branch_taken;
        redirTarget = branchTarget;
        redirBad    = 1'b0;
        if (jump_reg) begin
            redirTarget = jr_target;
            redirBad    = |jr_target[1:0];
        end else if (jump) begin
            redirTarget = jumpTarget(pcPlus4, jump_index);
        end

        nextTarget = pcPlus4;
        nextBad    = 1'b0;
        if (redirValid) begin
            nextTarget = redirTarget;
            nextBad    = redirBad;
        end else if (pendValid_q) begin
            nextTarget = pendTarget_q;
            nextBad    = pendBad_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pendValid_d  = pendValid_q;
        pendTarget_d = pendTarget_q;
        pendBad_d    = pendBad_q;
        fetchValid_d = fetchValid_q;
        misaligned_d = misaligned_q;
        case (state_q)
            ST_BOOT: begin
                state_d      = ST_FETCH;
                fetchValid_d = 1'b1;
            end
            ST_FETCH: begin
                if (advance) begin
                    pendValid_d = 1'b0;
                    if (nextBad) begin
                        state_d      = ST_HALT;
                        fetchValid_d = 1'b0;
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d = nextTarget;
                    end
                end else if (redirValid) begin
                    // Newest redirect replaces whatever was waiting.
                    pendValid_d  = 1'b1;
                    pendTarget_d = redirTarget;
                    pendBad_d    = redirBad;
                end
            end
            ST_HALT: begin
                fetchValid_d = 1'b0;
                misaligned_d = 1'b1;
            end
            default: begin
                state_d      = ST_BOOT;
                fetchValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            pendValid_q  <= 1'b0;
            pendTarget_q <= 32'h0;
            pendBad_q    <= 1'b0;
            fetchValid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pendValid_q  <= pendValid_d;
            pendTarget_q <= pendTarget_d;
            pendBad_q    <= pendBad_d;
            fetchValid_q <= fetchValid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pcPlus4;
    assign fetch_valid = fetchValid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences, random vs. model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] expPc;
        logic        expFv;
        logic        expMis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, branch_taken, jump, jump_reg;
    logic [31:0] branch_offset, jr_target;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, misaligned;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: fetch address, phase (0 boot, 1 fetch, 2 halted), trap flag, pending queue.
    logic [31:0] mPc;
    int          mMode;
    logic        mMis;
    logic [32:0] mPend[$];

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic stl, input logic rdy,
                                input logic br, input logic [31:0] off,
                                input logic jmp, input logic [25:0] idx,
                                input logic jr, input logic [31:0] jrt,
                                input logic [31:0] ePc, input logic eFv, input logic eMis);
        vec_t v;
        v.rst = rst; v.stall = stl; v.ready = rdy; v.br = br; v.off = off;
        v.jmp = jmp; v.idx = idx; v.jr = jr; v.jrt = jrt;
        v.expPc = ePc; v.expFv = eFv; v.expMis = eMis;
        return v;
    endfunction

    task automatic modelStep(input vec_t s);
        logic [31:0] p4, t;
        logic        bad, have;
        if (s.rst) begin
            mPc = RST_PC; mMode = 0; mMis = 1'b0; mPend.delete();
        end else if (mMode == 0) begin
            mMode = 1;
        end else if (mMode == 1) begin
            p4 = mPc + 32'd4;
            have = 1'b1; bad = 1'b0; t = p4;
            if (s.jr) begin
                t = s.jrt; bad = (s.jrt % 4) != 0;
            end else if (s.jmp) begin
                t = (p4 & 32'hF000_0000) + {4'b0, s.idx, 2'b00};
            end else if (s.br) begin
                t = p4 + s.off;
            end else begin
                have = 1'b0;
            end
            if (s.ready && !s.stall) begin
                if (!have && mPend.size() > 0) {bad, t} = mPend[0];
                mPend.delete();
                if (bad) begin
                    mMode = 2; mMis = 1'b1;
                end else begin
                    mPc = t;
                end
            end else if (have) begin
                mPend.delete();
                mPend.push_back({bad, t});
            end
        end
    endtask

    task automatic applyStimulus(input vec_t s);
        @(negedge clk);
        reset = s.rst; stall = s.stall; imem_ready = s.ready;
        branch_taken = s.br; branch_offset = s.off;
        jump = s.jmp; jump_index = s.idx;
        jump_reg = s.jr; jr_target = s.jrt;
        @(posedge clk);
        modelStep(s);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ePc,
                               input logic eFv, input logic eMis);
        logic [31:0] eP4;
        eP4 = ePc + 32'd4;
        vectors++;
        if (pc !== ePc || pc_plus4 !== eP4 || fetch_valid !== eFv || misaligned !== eMis) begin
            miscompares++;
            $display("[TB] FAIL %s: got pc=%h pc_plus4=%h fv=%b mis=%b, expected pc=%h pc_plus4=%h fv=%b mis=%b",
                     name, pc, pc_plus4, fetch_valid, misaligned, ePc, eP4, eFv, eMis);
        end
    endtask

    task automatic runVec(input string name, input vec_t s);
        applyStimulus(s);
        checkOutput(name, s.expPc, s.expFv, s.expMis);
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
        branch_offset = 32'h0; jump = 1'b0; jump_index = 26'h0;
        jump_reg = 1'b0; jr_target = 32'h0;
        mPc = RST_PC; mMode = 0; mMis = 1'b0;

        //               rst stl rdy br  off            jmp idx          jr  jrt            expPc          fv   mis
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0040_0000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0040_0000, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0040_0004, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0040_0008, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       1, 32'h0040_0010,  32'h0040_0010, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFF0,  0, 26'h0,       0, 32'h0,          32'h0040_0004, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       1, 32'h1040_0000,  32'h1040_0000, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0040,  1, 26'h0000100, 0, 32'h0,          32'h1000_0400, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h0000_0100,  0, 26'h0,       0, 32'h0,          32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0000_0104, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,          1, 26'h0000010, 0, 32'h0,          32'h0000_0104, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0020,  0, 26'h0,       0, 32'h0,          32'h0000_0104, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0000_0128, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0000_012C, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0010,  0, 26'h0,       0, 32'h0,          32'h0000_012C, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          1, 26'h0000080, 0, 32'h0,          32'h0000_0200, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,          32'h0000_0204, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            runVec($sformatf("table[%0d]", i), tbl[i]);
        end

        // Memory not ready for three cycles, branch seen only in the first.
        runVec("wait_br0",  mk(0, 0, 0, 1, 32'h0000_0100, 0, 26'h0, 0, 32'h0, 32'h0000_0204, 1, 0));
        runVec("wait_br1",  mk(0, 0, 0, 0, 32'h0,         0, 26'h0, 0, 32'h0, 32'h0000_0204, 1, 0));
        runVec("wait_br2",  mk(0, 0, 0, 0, 32'h0,         0, 26'h0, 0, 32'h0, 32'h0000_0204, 1, 0));
        runVec("wait_take", mk(0, 0, 1, 0, 32'h0,         0, 26'h0, 0, 32'h0, 32'h0000_0308, 1, 0));
        runVec("wait_seq",  mk(0, 0, 1, 0, 32'h0,         0, 26'h0, 0, 32'h0, 32'h0000_030C, 1, 0));

        // Misaligned JR traps, halt ignores redirects, boot ignores redirects, reset recovers.
        runVec("jr_trap",    mk(0, 0, 1, 0, 32'h0, 0, 26'h0,       1, 32'h0040_0002, 32'h0000_030C, 0, 1));
        runVec("halt_hold",  mk(0, 0, 1, 1, 32'h40,1, 26'h3FFFFFF, 0, 32'h0,         32'h0000_030C, 0, 1));
        runVec("halt_reset", mk(1, 0, 1, 0, 32'h0, 0, 26'h0,       0, 32'h0,         32'h0040_0000, 0, 0));
        runVec("boot_jump",  mk(0, 0, 1, 0, 32'h0, 1, 26'h3FFFFFF, 0, 32'h0,         32'h0040_0000, 1, 0));
        runVec("boot_after", mk(0, 0, 1, 0, 32'h0, 0, 26'h0,       0, 32'h0,         32'h0040_0004, 1, 0));
        runVec("jr_pend",    mk(0, 1, 1, 0, 32'h0, 0, 26'h0,       1, 32'h0040_0003, 32'h0040_0004, 1, 0));
        runVec("jr_pend_tr", mk(0, 0, 1, 0, 32'h0, 0, 26'h0,       0, 32'h0,         32'h0040_0004, 0, 1));
        runVec("trap_reset", mk(1, 1, 0, 0, 32'h0, 0, 26'h0,       0, 32'h0,         32'h0040_0000, 0, 0));

        for (int i = 0; i < 800; i++) begin
            vec_t s;
            s.rst   = ($urandom_range(0, 59) == 0) || (mMode == 2 && $urandom_range(0, 3) == 0);
            s.stall = ($urandom_range(0, 3) == 0);
            s.ready = ($urandom_range(0, 3) != 0);
            s.br    = ($urandom_range(0, 4) == 0);
            s.off   = $urandom & 32'hFFFF_FFFC;
            s.jmp   = ($urandom_range(0, 5) == 0);
            s.idx   = 26'($urandom);
            s.jr    = ($urandom_range(0, 5) == 0);
            s.jrt   = ($urandom_range(0, 11) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.expPc = 32'h0; s.expFv = 1'b0; s.expMis = 1'b0;
            applyStimulus(s);
            checkOutput($sformatf("random[%0d]", i), mPc, mMode == 1, mMis);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
